// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared matrix-keypad geometry for the keypad emulator and the
//            scanner it answers. Both ends import this package so that key
//            numbering and row/column idle levels can never drift apart.
// Contents : matrix size and index widths, idle levels for the row and
//            column lines, key-index to row/column split helpers, and the
//            emulator FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Matrix geometry: 4 rows x 4 columns, key index = row*4 + col.
    localparam int unsigned N_ROWS    = 4;
    localparam int unsigned N_COLS    = 4;
    localparam int unsigned KEY_W     = 4;
    localparam int unsigned ROW_IDX_W = 2;
    localparam int unsigned COL_IDX_W = 2;

    // Both line sets are active-low with pull-ups, so "nothing driven" is all ones.
    localparam logic [N_COLS-1:0] COLS_IDLE = 4'b1111;
    localparam logic [N_ROWS-1:0] ROWS_IDLE = 4'b1111;

    // Emulator FSM encoding. Kept as plain sized constants so older tools and
    // the scanner-side debug logic can decode the state without the enum type.
    localparam int unsigned ST_W = 3;
    typedef logic [ST_W-1:0] kp_state_t;

    localparam kp_state_t ST_IDLE     = 3'd0;
    localparam kp_state_t ST_P_BOUNCE = 3'd1;
    localparam kp_state_t ST_HOLD     = 3'd2;
    localparam kp_state_t ST_R_BOUNCE = 3'd3;
    localparam kp_state_t ST_RELEASE  = 3'd4;

    // Row number of a key: the upper half of the index.
    function automatic logic [ROW_IDX_W-1:0] key_row(input logic [KEY_W-1:0] key);
        return key[KEY_W-1:COL_IDX_W];
    endfunction

    // Column number of a key: the lower half of the index.
    function automatic logic [COL_IDX_W-1:0] key_col(input logic [KEY_W-1:0] key);
        return key[COL_IDX_W-1:0];
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_emulator_bounce_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : bounce_lfsr
// Purpose  : 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) used as the
//            contact-bounce pattern source. It advances only while enabled so
//            the bounce sequence is continuous across presses and is restarted
//            only by reset.
// Ports    : clk   - clock
//            rst   - synchronous active-high reset, loads SEED
//            en_i  - advance one step at the next clock edge
//            bit_o - current bit 0 of the register (the bounce sample)
// Revision : 1.0 - initial release
// ============================================================================
module bounce_lfsr #(
    // Must be nonzero: an all-zero register is the lock-up state.
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic bit_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb;

    // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5 and the
    // feedback enters at bit 15.
    always_comb begin
        fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {fb, lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule : bounce_lfsr
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator
// Purpose  : Responder end of a 4x4 active-low matrix keypad. Watches the row
//            lines driven by a scanner and pulls the matching column low while
//            the emulated switch is closed. A press request (key, hold time,
//            bounce enable) plays out as press bounce, stable hold, release
//            bounce and a release cycle.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/req_ready - press request handshake
//            req_key             - key index row*4+col
//            req_hold            - stable-contact time in cycles (0 allowed)
//            req_bounce          - 1 = add bounce windows around the hold
//            rows                - active-low rows from the scanner (async)
//            cols                - active-low registered column return
//            busy                - a press is in progress
//            done                - one-cycle pulse when a press has finished
//            contact             - internal switch-closed state
// Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned BOUNCE_CYC  = 64,
    parameter int unsigned HOLD_W      = 24,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [HOLD_W-1:0] req_hold,
    input  logic              req_bounce,
    input  logic [N_ROWS-1:0] rows,
    output logic [N_COLS-1:0] cols,
    output logic              busy,
    output logic              done,
    output logic              contact
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Bounce counter spans 0..BOUNCE_CYC; keep at least one bit when bounce is
    // compiled out so the counter still has a legal width.
    localparam int unsigned BCNT_W = (BOUNCE_CYC > 0) ? $clog2(BOUNCE_CYC + 1) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = (BOUNCE_CYC > 0) ? BCNT_W'(BOUNCE_CYC - 1) : '0;
    localparam logic [BCNT_W-1:0] BCNT_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
    localparam bit                BOUNCE_AVAIL = (BOUNCE_CYC != 0);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [N_ROWS-1:0] sync_q [SYNC_STAGES];
    logic [N_ROWS-1:0] rows_s;

    kp_state_t         state_q,    state_d;
    logic [KEY_W-1:0]  key_q,      key_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic              bounce_q,   bounce_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [BCNT_W-1:0] bcnt_q,     bcnt_d;
    logic              done_q,     done_d;
    logic [N_COLS-1:0] cols_q,     cols_d;

    logic              bounce_req;
    logic              lfsr_en;
    logic              lfsr_bit;
    logic              contact_w;

    // ------------------------------------------------------------------------
    // Row synchronizer: rows come from another board / pin, so treat them as
    // asynchronous. Reset to the pulled-up level so nothing answers at reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= ROWS_IDLE;
            end
        end else begin
            sync_q[0] <= rows;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rows_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Bounce pattern source
    // ------------------------------------------------------------------------
    bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_bounce_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (lfsr_en),
        .bit_o (lfsr_bit)
    );

    assign lfsr_en = (state_q == ST_P_BOUNCE) || (state_q == ST_R_BOUNCE);

    // A bounce request is meaningless when the window length is zero.
    assign bounce_req = req_bounce && BOUNCE_AVAIL;

    // ------------------------------------------------------------------------
    // Phase sequencing helpers. Zero-length phases are skipped entirely rather
    // than spending a cycle in them.
    // ------------------------------------------------------------------------
    function automatic kp_state_t after_hold(input logic bnc);
        return bnc ? ST_R_BOUNCE : ST_RELEASE;
    endfunction

    function automatic kp_state_t after_press(input logic [HOLD_W-1:0] hold, input logic bnc);
        return (hold == '0) ? after_hold(bnc) : ST_HOLD;
    endfunction

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        hold_d     = hold_q;
        bounce_d   = bounce_q;
        hold_cnt_d = hold_cnt_q;
        bcnt_d     = bcnt_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    key_d      = req_key;
                    hold_d     = req_hold;
                    bounce_d   = bounce_req;
                    hold_cnt_d = '0;
                    bcnt_d     = '0;
                    state_d    = bounce_req ? ST_P_BOUNCE : after_press(req_hold, bounce_req);
                end
            end

            ST_P_BOUNCE: begin
                if (bcnt_q == BCNT_LAST) begin
                    bcnt_d  = '0;
                    state_d = after_press(hold_q, bounce_q);
                end else begin
                    bcnt_d = (bcnt_q == BCNT_MAX) ? bcnt_q : bcnt_q + BCNT_W'(1);
                end
            end

            ST_HOLD: begin
                // hold_q is nonzero here, so hold_q-1 cannot underflow.
                if (hold_cnt_q == hold_q - HOLD_W'(1)) begin
                    hold_cnt_d = '0;
                    bcnt_d     = '0;
                    state_d    = after_hold(bounce_q);
                end else begin
                    hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
                end
            end

            ST_R_BOUNCE: begin
                if (bcnt_q == BCNT_LAST) begin
                    bcnt_d  = '0;
                    state_d = ST_RELEASE;
                end else begin
                    bcnt_d = (bcnt_q == BCNT_MAX) ? bcnt_q : bcnt_q + BCNT_W'(1);
                end
            end

            ST_RELEASE: begin
                // done is registered, so it shows in the first IDLE cycle and
                // holds off the next acceptance for that one cycle.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Switch state and column return
    // ------------------------------------------------------------------------
    always_comb begin
        contact_w = 1'b0;
        case (state_q)
            ST_HOLD:     contact_w = 1'b1;
            ST_P_BOUNCE: contact_w = lfsr_bit;
            ST_R_BOUNCE: contact_w = lfsr_bit;
            default:     contact_w = 1'b0;
        endcase
    end

    // Only the latched key's own row is consulted: several low rows do not
    // create phantom keys.
    always_comb begin
        cols_d = COLS_IDLE;
        if (contact_w && !rows_s[key_row(key_q)]) begin
            cols_d[key_col(key_q)] = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            hold_q     <= '0;
            bounce_q   <= 1'b0;
            hold_cnt_q <= '0;
            bcnt_q     <= '0;
            done_q     <= 1'b0;
            cols_q     <= COLS_IDLE;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            hold_q     <= hold_d;
            bounce_q   <= bounce_d;
            hold_cnt_q <= hold_cnt_d;
            bcnt_q     <= bcnt_d;
            done_q     <= done_d;
            cols_q     <= cols_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Ready stays low during the done cycle so back-to-back presses
    // are always separated by the done pulse.
    // ------------------------------------------------------------------------
    assign req_ready = (state_q == ST_IDLE) && !done_q;
    assign busy      = !req_ready;
    assign done      = done_q;
    assign contact   = contact_w;
    assign cols      = cols_q;

endmodule : keypad_emulator
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_keypad_emulator
// Purpose  : Self-checking bench for keypad_emulator. A transaction-level
//            model turns each accepted request into a per-cycle list of
//            expected contact/done values, and derives cols from that list and
//            a delayed copy of the row lines. Directed scenarios are followed
//            by randomized presses with random row activity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;
    import keypad_pkg::*;

    localparam int          BOUNCE_CYC  = 64;
    localparam int          HOLD_W      = 24;
    localparam int          SYNC_STAGES = 2;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_key;
    logic [HOLD_W-1:0] req_hold;
    logic              req_bounce;
    logic [3:0]        rows;
    logic [3:0]        cols;
    logic              busy;
    logic              done;
    logic              contact;

    always #20 clk = ~clk;

    keypad_emulator #(
        .BOUNCE_CYC  (BOUNCE_CYC),
        .HOLD_W      (HOLD_W),
        .SYNC_STAGES (SYNC_STAGES),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_key    (req_key),
        .req_hold   (req_hold),
        .req_bounce (req_bounce),
        .rows       (rows),
        .cols       (cols),
        .busy       (busy),
        .done       (done),
        .contact    (contact)
    );

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic c;   // switch closed this cycle
        logic d;   // done pulse this cycle
    } exp_t;

    exp_t       mq[$];
    int         m_lfsr;
    int         m_key;
    logic [3:0] m_sync [SYNC_STAGES];
    logic [3:0] m_cols;
    logic [3:0] m_rs;
    logic       m_cur_c;
    bit         m_ready;
    bit         m_live = 0;

    function automatic int lfsr_next(input int l);
        int b;
        b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    task automatic model_press(input int key, input int hold, input logic bnc);
        exp_t e;
        m_key = key;
        if (bnc) begin
            for (int k = 0; k < BOUNCE_CYC; k++) begin
                e.c = logic'(m_lfsr & 1); e.d = 1'b0; mq.push_back(e);
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
        for (int k = 0; k < hold; k++) begin
            e.c = 1'b1; e.d = 1'b0; mq.push_back(e);
        end
        if (bnc) begin
            for (int k = 0; k < BOUNCE_CYC; k++) begin
                e.c = logic'(m_lfsr & 1); e.d = 1'b0; mq.push_back(e);
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
        e.c = 1'b0; e.d = 1'b0; mq.push_back(e);   // release cycle
        e.c = 1'b0; e.d = 1'b1; mq.push_back(e);   // done cycle
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_lfsr = int'(SEED);
            for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 4'hF;
            m_cols = 4'hF;
            m_live = 1;
        end else if (m_live) begin
            m_cur_c = (mq.size() != 0) ? mq[0].c : 1'b0;
            m_rs    = m_sync[SYNC_STAGES-1];
            m_cols  = 4'hF;
            if (m_cur_c && (m_rs[m_key / 4] == 1'b0)) m_cols[m_key % 4] = 1'b0;
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = rows;
            m_ready = (mq.size() == 0);
            if (!m_ready) void'(mq.pop_front());
            if (m_ready && req_valid) model_press(int'(req_key), int'(req_hold), req_bounce);
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check_eq("cols",      32'(cols),      32'(m_cols));
            check_eq("contact",   32'(contact),   32'((mq.size() != 0) ? mq[0].c : 1'b0));
            check_eq("done",      32'(done),      32'((mq.size() != 0) ? mq[0].d : 1'b0));
            check_eq("busy",      32'(busy),      32'(mq.size() != 0));
            check_eq("req_ready", 32'(req_ready), 32'(mq.size() == 0));
        end
    end

    // ------------------------------------------------------------------------
    // Row driver: 0 = static, 1 = scanner-like rotation, 2 = random
    // ------------------------------------------------------------------------
    int         rows_mode   = 0;
    logic [3:0] rows_static = 4'b1110;
    int         scan_cnt    = 0;
    logic [3:0] one_hot     = 4'b0001;

    initial begin
        rows = 4'hF;
        forever begin
            @(posedge clk);
            #1;
            scan_cnt++;
            case (rows_mode)
                1:       rows = ~(one_hot << ((scan_cnt / 4) % 4));
                2:       rows = 4'($urandom);
                default: rows = rows_static;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called at #1 after a rising edge)
    // ------------------------------------------------------------------------
    logic cbuf [2048];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] key, input int hold, input logic bnc, output int waited);
        bit ok = 0;
        req_valid  = 1'b1;
        req_key    = key;
        req_hold   = HOLD_W'(hold);
        req_bounce = bnc;
        waited     = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            waited++;
            if (req_ready) begin ok = 1; break; end
        end
        check_eq("send_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the fields: they must only matter at acceptance.
        req_valid  = 1'b0;
        req_key    = 4'($urandom);
        req_hold   = HOLD_W'($urandom);
        req_bounce = 1'($urandom);
    endtask

    task automatic measure(input logic [3:0] want, output int nb, output int nd, output int nc);
        bit fin = 0;
        nb = 0; nd = 0; nc = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (k < 2048) cbuf[k] = contact;
            if (!busy) begin fin = 1; break; end
            nb++;
            if (done) nd++;
            if (cols == want) nc++;
        end
        check_eq("press_ends", 32'(fin), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit fin = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (req_ready) begin fin = 1; break; end
        end
        check_eq("wait_idle", 32'(fin), 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic int toggles(input int a, input int b);
        int t = 0;
        for (int k = a + 1; k < b; k++) if (cbuf[k] != cbuf[k-1]) t++;
        return t;
    endfunction

    // ------------------------------------------------------------------------
    // Scenario
    // ------------------------------------------------------------------------
    int nb, nd, nc, waited, ones, nidle;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_key = '0; req_hold = '0; req_bounce = 1'b0;
        tick(3);
        rst = 1'b0;

        // Idle with a static low row: nothing answers.
        rows_mode = 0; rows_static = 4'b1110;
        nidle = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cols == 4'hF && req_ready && !busy) nidle++;
        end
        check_eq("idle_100", 32'(nidle), 32'd100);
        tick(1);

        // Key 6 (row 1, col 2), hold 50, clean edges.
        rows_static = 4'b1101;
        tick(4);
        send(4'h6, 50, 1'b0, waited);
        measure(4'b1011, nb, nd, nc);
        check_eq("k6_busy_len", 32'(nb), 32'd52);
        check_eq("k6_done_cnt", 32'(nd), 32'd1);
        check_eq("k6_cols_len", 32'(nc), 32'd50);

        // Same key with a rotating scanner.
        rows_mode = 1;
        send(4'h6, 200, 1'b0, waited);
        wait_idle();

        // Bounce windows around a long hold.
        rows_mode = 0; rows_static = 4'b1101;
        tick(4);
        send(4'h6, 1000, 1'b1, waited);
        measure(4'b1011, nb, nd, nc);
        check_eq("bnc_busy_len", 32'(nb), 32'(2 * BOUNCE_CYC + 1000 + 2));
        check_eq("bnc_done_cnt", 32'(nd), 32'd1);
        check_eq("bnc_p_toggles", 32'(toggles(0, BOUNCE_CYC) > 0), 32'd1);
        check_eq("bnc_r_toggles", 32'(toggles(BOUNCE_CYC + 1000, 2 * BOUNCE_CYC + 1000) > 0), 32'd1);
        ones = 0;
        for (int k = BOUNCE_CYC; k < BOUNCE_CYC + 1000; k++) if (cbuf[k]) ones++;
        check_eq("bnc_hold_len", 32'(ones), 32'd1000);

        // Second request held while busy: waits for ready, key F on row 3.
        rows_static = 4'b0111;
        tick(4);
        send(4'h6, 30, 1'b0, waited);
        send(4'hF, 20, 1'b0, waited);
        check_eq("b2b_wait", 32'(waited), 32'(30 + 3));
        measure(4'b0111, nb, nd, nc);
        check_eq("kF_busy_len", 32'(nb), 32'd22);
        check_eq("kF_cols_len", 32'(nc), 32'd20);

        // Reset in the middle of HOLD.
        rows_static = 4'b1011;
        tick(4);
        send(4'h9, 100, 1'b0, waited);
        tick(20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_cols", 32'(cols), 32'hF);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check_eq("rst_no_done", 32'(nd), 32'd0);
        tick(1);
        send(4'h9, 10, 1'b0, waited);
        measure(4'b1101, nb, nd, nc);
        check_eq("post_rst_busy", 32'(nb), 32'd12);
        check_eq("post_rst_cols", 32'(nc), 32'd10);

        // Zero hold, with and without bounce.
        rows_static = 4'b1110;
        tick(4);
        send(4'h2, 0, 1'b0, waited);
        measure(4'b1011, nb, nd, nc);
        check_eq("h0_busy", 32'(nb), 32'd2);
        check_eq("h0_cols", 32'(nc), 32'd0);
        send(4'h2, 0, 1'b1, waited);
        measure(4'b1011, nb, nd, nc);
        check_eq("h0b_busy", 32'(nb), 32'(2 * BOUNCE_CYC + 2));

        // Randomized presses with random row activity.
        for (int it = 0; it < 40; it++) begin
            rows_mode   = int'($urandom_range(0, 2));
            rows_static = 4'($urandom);
            tick(int'($urandom_range(1, 4)));
            send(4'($urandom), int'($urandom_range(0, 40)), 1'($urandom_range(0, 3) == 0), waited);
        end
        wait_idle();
        tick(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_keypad_emulator
`default_nettype wire

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Responder end of the 4x4 matrix keypad interface: watches the row lines the scanner drives and drives the column lines exactly as a physical keypad would.
- Used in benches, and on a second board, to inject player inputs: a press request with a hold time produces a press, optional contact bounce, a hold, then a release.
- Sits between a stimulus source (testbench or a host UART bridge) and the scanner's row/column pins.

Parameters:
- BOUNCE_CYC, 64, length in clk cycles of the bounce window after press and after release; 0 disables bounce.
- HOLD_W, 24, width of the hold-time request field, in clk cycles.
- SYNC_STAGES, 2, synchronizer depth on the incoming row lines (legal range 2..3).
- LFSR_SEED, 16'hACE1, reset seed of the bounce pattern generator; must be nonzero.

Ports:
- clk  in  1  clock; same 25 MHz domain as the scanner.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  press request valid.
- req_ready  out  1  high only in IDLE; a request is accepted on a cycle where req_valid & req_ready.
- req_key  in  4  key index, row*4+col (row 0 = first row line, col 0 = first column line).
- req_hold  in  HOLD_W  stable-contact hold time in cycles; 0 is legal and gives no stable-held phase.
- req_bounce  in  1  1 = apply bounce windows, 0 = clean edges.
- rows  in  4  active-low row drive from the scanner; at most one is expected low.
- cols  out  4  active-low column return; idle value 4'b1111 (pulled-up level).
- busy  out  1  high from acceptance until the end of the release phase.
- done  out  1  one-cycle pulse on return to IDLE.
- contact  out  1  internal switch-closed state, for debug and LED.

Behaviour:
- Reset values: cols = 4'b1111, req_ready = 1, busy = 0, done = 0, contact = 0, FSM = IDLE, LFSR = LFSR_SEED, synchronizer flops = 4'b1111.
- rows pass through SYNC_STAGES flops to give rows_s.
- Column output is registered: cols[c] = 0 iff contact = 1, c = latched col, and rows_s[latched row] = 0. Otherwise cols[c] = 1.
- If several rows are low, the key still answers only on its own row (no ghosting model).
- Latency from a row falling at the pin to the column falling is SYNC_STAGES+1 cycles.
- FSM states:
  - IDLE: req_ready = 1. On acceptance, latch key, hold and bounce, go to P_BOUNCE, and set busy the next cycle.
  - P_BOUNCE: counter runs 0..BOUNCE_CYC-1. contact = LFSR[0] each cycle and the LFSR steps every cycle. On terminal count go to HOLD. Skipped (straight to HOLD) if bounce is disabled or BOUNCE_CYC = 0.
  - HOLD: contact = 1 for exactly req_hold cycles, then go to R_BOUNCE. req_hold = 0 passes straight to R_BOUNCE.
  - R_BOUNCE: same as P_BOUNCE, then go to RELEASE.
  - RELEASE: contact = 0 for one cycle, done = 1, then IDLE.
- The LFSR is 16-bit Fibonacci with taps 16,14,13,11. It steps only in bounce states and is never reseeded except on reset.
- A request arriving while busy is not accepted; req_valid must stay asserted until ready (valid/ready rule). req_key, req_hold and req_bounce are sampled only at acceptance.
- Counters saturate and never wrap. The hold counter is HOLD_W wide; the bounce counter is clog2(BOUNCE_CYC+1) wide.
- Back-to-back: req_ready returns one cycle after done. Minimum gap between presses is 2 cycles plus the bounce windows.
- rst asserted mid-press: FSM returns to IDLE on the next edge and cols = 1111 that same edge. No done pulse is generated.

Decomposition:
- Shared package keypad_pkg:
  - row/column count (4/4) and key index width (4).
  - the key-index-to-row/col split functions.
  - the idle level constant COLS_IDLE = 4'b1111.
  - the FSM state enum.
- The scanner should import the same package so both ends agree on the matrix geometry.
- One natural sub-module, bounce_lfsr: 16-bit LFSR with enable, seed parameter and synchronous reset.
- Synchronizer and FSM stay inline.

Test Plan:
- Reset release, rows = 4'b1110 static, no request: cols = 4'b1111 for 100 cycles; req_ready = 1; busy = 0.
- req_key = 4'h6 (row 1, col 2), req_hold = 50, bounce off, rows held at 4'b1101:
  - cols = 4'b1011 starts 1 cycle after acceptance and lasts exactly 50 cycles;
  - done pulses once; total busy = 52 cycles.
- Same key, rows cycling the one-hot-low pattern every 4 cycles (scanner-like):
  - cols goes low only while row 1 is low, after 3 cycles of latency;
  - any other row low gives cols = 4'b1111.
- req_bounce = 1, BOUNCE_CYC = 64, hold = 1000:
  - contact toggles at least once in each bounce window and is stable high for exactly 1000 cycles;
  - LFSR sequence matches the reference model from seed 16'hACE1.
- req_valid held high during a press with a second key 4'hF: not accepted until req_ready; the second press starts 1 cycle after done with key F (cols[3] responds to rows[3]).
- rst pulsed in the middle of HOLD: cols = 4'b1111 and req_ready = 1 on the following cycle; no done pulse; a new request then completes normally.
